// File: rtl/booth_pkg.sv
// booth_pkg -- shared types and helpers for the radix-4 Booth sequential multiplier.
//   state_t : control FSM states (IDLE, RUN, DONE)
//   digit_t : radix-4 Booth digit {ZERO, POS1, POS2, NEG1, NEG2}
//   n_iter  : number of Booth digits retired for a given operand width
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_t;

    // Operands are extended by two bits, so (WORD_LEN+2)/2 digits cover them.
    function automatic int unsigned n_iter(input int unsigned word_len);
        return word_len / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_enc.sv
// booth_enc -- combinational radix-4 Booth recoder.
//   win_i   [2:0] : multiplier window {b[2i+1], b[2i], b[2i-1]}
//   digit_o       : recoded digit in {-2,-1,0,+1,+2}
module booth_enc
    import booth_pkg::*;
(
    input  logic [2:0] win_i,
    output digit_t     digit_o
);

    always_comb begin
        digit_o = ZERO;
        case (win_i)
            3'b001, 3'b010: digit_o = POS1;
            3'b011:         digit_o = POS2;
            3'b100:         digit_o = NEG2;
            3'b101, 3'b110: digit_o = NEG1;
            default:        digit_o = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq -- sequential radix-4 Booth multiplier, one digit per RUN cycle.
//   i_clk, i_rst               : clock, synchronous active-high reset
//   i_valid / o_ready          : operand handshake (accepted only in IDLE)
//   i_multiplier, i_multiplicand [WORD_LEN-1:0], i_signed : operands and mode
//   o_valid / i_ready          : result handshake (result held under back-pressure)
//   o_result [2*WORD_LEN-1:0]  : full-precision product
// Optional build macro BOOTH_MUL_ACC_EN adds input i_acc: when captured as 1,
// the product is added onto the previously delivered result (mod 2^(2*WORD_LEN)).
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WORD_LEN = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [WORD_LEN-1:0]     i_multiplier,
    input  logic [WORD_LEN-1:0]     i_multiplicand,
    input  logic                    i_signed,
`ifdef BOOTH_MUL_ACC_EN
    input  logic                    i_acc,
`endif
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [2*WORD_LEN-1:0]   o_result
);

    if ((WORD_LEN < 4) || ((WORD_LEN % 2) != 0)) begin : g_bad_word_len
        $error("booth_mul_seq: WORD_LEN must be even and at least 4");
    end

    localparam int unsigned EW     = WORD_LEN + 2;       // extended operand width
    localparam int unsigned AW     = 2 * WORD_LEN + 4;   // accumulator width
    localparam int unsigned N_ITER = n_iter(WORD_LEN);
    localparam int unsigned CW     = $clog2(N_ITER + 1);

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [EW:0]             mplr_q;     // extended multiplier with implicit b[-1]=0 at bit 0
    logic [AW-1:0]           mcand_q;    // extended multiplicand, shifted left 2 per digit
    logic [AW-1:0]           acc_q;
    logic [2*WORD_LEN-1:0]   o_result_q;
    logic                    o_valid_q;
    logic                    o_ready_q;
`ifdef BOOTH_MUL_ACC_EN
    logic                    acc_mode_q;
`endif

    logic                    mplr_sx;
    logic                    mcand_sx;
    logic [EW:0]             mplr_ext;
    logic [AW-1:0]           mcand_ext;
    digit_t                  digit;
    logic [AW-1:0]           addend;
    logic [2*WORD_LEN-1:0]   acc_base;
    logic [2*WORD_LEN-1:0]   result_next;

    always_comb begin
        mplr_sx   = i_signed & i_multiplier[WORD_LEN-1];
        mcand_sx  = i_signed & i_multiplicand[WORD_LEN-1];
        mplr_ext  = {{2{mplr_sx}}, i_multiplier, 1'b0};
        mcand_ext = {{(AW - WORD_LEN){mcand_sx}}, i_multiplicand};
    end

    booth_enc u_enc (
        .win_i   (mplr_q[2:0]),
        .digit_o (digit)
    );

    // Partial product for the current digit; negation is modulo 2^AW, which
    // is exact because the true product always fits in the low 2*WORD_LEN bits.
    always_comb begin
        addend = '0;
        case (digit)
            POS1:    addend = mcand_q;
            POS2:    addend = mcand_q << 1;
            NEG1:    addend = -mcand_q;
            NEG2:    addend = -(mcand_q << 1);
            default: addend = '0;
        endcase
    end

    always_comb begin
`ifdef BOOTH_MUL_ACC_EN
        acc_base = acc_mode_q ? o_result_q : '0;
`else
        acc_base = '0;
`endif
        result_next = acc_q[2*WORD_LEN-1:0] + acc_base;
    end

    // RUN spends N_ITER cycles retiring digits and one more cycle registering
    // the result, giving o_valid N_ITER+1 cycles after the accepting edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mplr_q     <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            o_result_q <= '0;
            o_valid_q  <= 1'b0;
            o_ready_q  <= 1'b1;
`ifdef BOOTH_MUL_ACC_EN
            acc_mode_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        mplr_q     <= mplr_ext;
                        mcand_q    <= mcand_ext;
                        acc_q      <= '0;
                        cnt_q      <= '0;
`ifdef BOOTH_MUL_ACC_EN
                        acc_mode_q <= i_acc;
`endif
                        o_ready_q  <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_q != CW'(N_ITER)) begin
                        acc_q   <= acc_q + addend;
                        mcand_q <= mcand_q << 2;
                        mplr_q  <= mplr_q >> 2;
                        cnt_q   <= cnt_q + CW'(1);
                    end else begin
                        o_result_q <= result_next;
                        o_valid_q  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid_q <= 1'b0;
                        o_ready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    o_valid_q <= 1'b0;
                    o_ready_q <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_ready  = o_ready_q;
    assign o_valid  = o_valid_q;
    assign o_result = o_result_q;

endmodule

// File: doc/booth_mul_seq.md
BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default 8, the operand width; it SHALL be even and at least 4, and elaboration SHALL fail otherwise.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_valid, input, 1 bit: operands presented.
REQ-005 The block SHALL have port o_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have ports i_multiplier and i_multiplicand, input, WORD_LEN bits each: the operands.
REQ-007 The block SHALL have port i_signed, input, 1 bit: 1 means two's-complement operands, 0 means unsigned operands.
REQ-008 The block SHALL have port o_valid, output, 1 bit: o_result holds a completed result.
REQ-009 The block SHALL have port i_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port o_result, output, 2*WORD_LEN bits: the product, signed or unsigned per the captured i_signed.

Function
REQ-011 An operation SHALL be accepted on a rising edge where i_valid and o_ready are both 1; operands and i_signed are captured at that edge, and later input changes are ignored.
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on accept.
- RUN -> DONE after N_ITER = WORD_LEN/2+1 cycles.
- DONE -> IDLE on an edge where i_ready is 1.
REQ-013 o_ready SHALL be 1 only in IDLE; i_valid in RUN or DONE is ignored and never queued.
REQ-014 o_valid SHALL be 1 only in DONE, first asserted exactly N_ITER+1 cycles after the accepting edge (6 cycles for WORD_LEN=8), independent of operand values and mode.
REQ-015 Each RUN cycle SHALL retire one radix-4 Booth digit (recoding in {-2,-1,0,+1,+2}) of the multiplier, with operands extended to WORD_LEN+2 bits (sign-extended if signed, zero-extended if unsigned).
REQ-016 o_result SHALL equal the exact full-precision product for all operand pairs in both modes; no overflow is possible, e.g. signed -128*-128 = 0x4000 and unsigned 255*255 = 0xFE01.
REQ-017 o_result SHALL be held stable while o_valid=1 and i_ready=0 (back-pressure).
REQ-018 An accept SHALL NOT occur in the same cycle as a DONE->IDLE release; a new operation is accepted at the earliest on the following edge.

Reset
REQ-019 While i_rst=1 at an edge, the FSM SHALL go to IDLE, o_valid SHALL be 0, o_result SHALL be 0 and the internal accumulator SHALL be 0; o_ready SHALL be 1 from the first edge after reset deassertion.
REQ-020 A reset in RUN or DONE SHALL abort the operation with no result delivered; i_rst SHALL take priority over accept on the same edge.

Configuration
REQ-021 With the macro BOOTH_MUL_ACC_EN defined, the block SHALL add an input i_acc, 1 bit, captured at accept.
- If i_acc=1, o_result = product + previous delivered o_result, modulo 2^(2*WORD_LEN).
- If i_acc=0, o_result = product.
REQ-022 Without BOOTH_MUL_ACC_EN, i_acc SHALL be absent and every result SHALL be the plain product; latency is identical in both builds.

Structure
REQ-023 A shared package booth_pkg SHALL hold:
- the FSM state enum typedef;
- the Booth digit enum typedef ({ZERO, POS1, POS2, NEG1, NEG2});
- a function computing N_ITER from WORD_LEN.
REQ-024 A combinational sub-module booth_enc SHALL map a 3-bit multiplier window to a Booth digit; booth_mul_seq SHALL instantiate it once.

Verification
REQ-025 Reset, then a signed multiply (WORD_LEN=8, i_signed=1): 7 * -3 -> o_valid 6 cycles after accept, o_result = 0xFFEB (-21).
REQ-026 Unsigned corner: i_signed=0, 255 * 255 -> o_result = 0xFE01; signed corner: -128 * -128 -> o_result = 0x4000; signed 127 * -128 -> 0xC080.
REQ-027 Back-pressure: hold i_ready=0 for 10 cycles after o_valid -> o_result stable and o_ready=0 throughout; an i_valid pulse during this time is ignored.
REQ-028 Reset mid-RUN: assert i_rst 3 cycles after accepting 5*5 -> no o_valid, o_result=0, o_ready=1 after release; then 2*3 -> 6.
REQ-029 With BOOTH_MUL_ACC_EN: 10*10 (i_acc=0), then 3*4 (i_acc=1) -> results 100 then 112; then 0x7FFF-class wrap check: signed -1*-1 accumulated onto 0xFFFF -> 0x0000.
REQ-030 A randomized run of 1000 operations with random i_signed, random i_ready stalls and a scoreboard SHALL produce zero mismatches against a reference product.
